// File: rtl/poly_pipe_inverse_solver_if.sv
// Request/response bundle for poly_pipe_inverse_solver.
interface poly_pipe_inverse_solver_if #(
    parameter int WLx   = 6,
    parameter int WLa   = 2,
    parameter int WLb   = 3,
    parameter int WLc   = 4,
    parameter int WLmul = WLx + WLa,
    parameter int WLadd = ((WLmul > WLb) ? WLmul : WLb) + 1,
    parameter int WLy   = WLadd + WLc
);
    logic                  start;
    logic signed [WLy-1:0] y;
    logic signed [WLa-1:0] a;
    logic signed [WLb-1:0] b;
    logic signed [WLc-1:0] c;
    logic                  busy;
    logic                  done;
    logic signed [WLx-1:0] x;
    logic                  inexact;
    logic                  div0;
    logic                  ovf;

    modport master (
        output start, y, a, b, c,
        input  busy, done, x, inexact, div0, ovf
    );

    modport slave (
        input  start, y, a, b, c,
        output busy, done, x, inexact, div0, ovf
    );
endinterface

// File: rtl/poly_pipe_inverse_solver.sv
// Recovers x = ((y/c)-b)/a with two serial restoring divides sharing one datapath.
// Define POLY_INV_SAT_EN to saturate x on overflow instead of wrapping.
module poly_pipe_inverse_solver #(
    parameter int WLx   = 6,
    parameter int WLa   = 2,
    parameter int WLb   = 3,
    parameter int WLc   = 4,
    parameter int WLmul = WLx + WLa,
    parameter int WLadd = ((WLmul > WLb) ? WLmul : WLb) + 1,
    parameter int WLy   = WLadd + WLc
) (
    input logic clk,
    input logic rst,
    poly_pipe_inverse_solver_if.slave bus
);
    localparam int QW = WLy + 1;
    localparam int DW = (WLc > WLa) ? WLc : WLa;
    localparam int CW = $clog2(WLy + 2);
    localparam logic signed [QW:0] XMAX = (QW + 1)'(2 ** (WLx - 1) - 1);
    localparam logic signed [QW:0] XMIN = (QW + 1)'(-(2 ** (WLx - 1)));

    typedef enum logic [2:0] {IDLE, DIV1, SUB, DIV2, FIN} state_t;

    state_t state, nxt;

    logic                  ysn;
    logic signed [WLa-1:0] ar;
    logic signed [WLb-1:0] br;
    logic signed [WLc-1:0] cr;
    logic [QW-1:0]         qr;
    logic [DW-1:0]         r;
    logic [CW-1:0]         cnt;
    logic                  neg2;

    logic                  done_q, inexact_q, div0_q, ovf_q;
    logic signed [WLx-1:0] x_q;

    logic                  ld, step, sub_en, fin_en;
    logic                  zero_div;
    logic [WLy-1:0]        mag_yin;
    logic [WLa-1:0]        mag_a;
    logic [WLc-1:0]        mag_c;
    logic [DW-1:0]         dv;
    logic [DW:0]           rsh;
    logic                  take;
    logic [DW-1:0]         rnext;
    logic signed [QW-1:0]  q1u, q1, t;
    logic [QW-1:0]         mag_t;
    logic signed [QW:0]    q2u, q2;
    logic                  ovf_c;
    logic [WLx-1:0]        xval;

    assign zero_div = (bus.a == '0) || (bus.c == '0);
    assign mag_yin  = bus.y[WLy-1] ? -bus.y : bus.y;
    assign mag_a    = ar[WLa-1] ? -ar : ar;
    assign mag_c    = cr[WLc-1] ? -cr : cr;

    // One restoring step: shift the next dividend bit into the remainder.
    assign dv    = (state == DIV2) ? DW'(mag_a) : DW'(mag_c);
    assign rsh   = {r, qr[QW-1]};
    assign take  = rsh >= {1'b0, dv};
    assign rnext = take ? DW'(rsh - {1'b0, dv}) : rsh[DW-1:0];

    assign q1u   = $signed({1'b0, qr[WLy-1:0]});
    assign q1    = (ysn ^ cr[WLc-1]) ? -q1u : q1u;
    assign t     = q1 - {{(QW - WLb){br[WLb-1]}}, br};
    assign mag_t = t[QW-1] ? -t : t;

    assign q2u   = $signed({1'b0, qr});
    assign q2    = neg2 ? -q2u : q2u;
    assign ovf_c = (q2 > XMAX) || (q2 < XMIN);

`ifdef POLY_INV_SAT_EN
    assign xval = ovf_c ? (q2[QW] ? XMIN[WLx-1:0] : XMAX[WLx-1:0])
                        : q2[WLx-1:0];
`else
    assign xval = q2[WLx-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (bus.start) nxt = zero_div ? FIN : DIV1;
            DIV1: if (cnt == '0) nxt = SUB;
            SUB:  nxt = DIV2;
            DIV2: if (cnt == '0) nxt = FIN;
            FIN:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ld     = 1'b0;
        step   = 1'b0;
        sub_en = 1'b0;
        fin_en = 1'b0;
        unique case (1'b1)
            (state == IDLE): ld = bus.start;
            (state == DIV1),
            (state == DIV2): step = 1'b1;
            (state == SUB):  sub_en = 1'b1;
            (state == FIN):  fin_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ysn       <= 1'b0;
            ar        <= '0;
            br        <= '0;
            cr        <= '0;
            qr        <= '0;
            r         <= '0;
            cnt       <= '0;
            neg2      <= 1'b0;
            done_q    <= 1'b0;
            inexact_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            x_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (ld) begin
                ysn       <= bus.y[WLy-1];
                ar        <= bus.a;
                br        <= bus.b;
                cr        <= bus.c;
                qr        <= {mag_yin, 1'b0};
                r         <= '0;
                cnt       <= CW'(WLy - 1);
                inexact_q <= 1'b0;
                div0_q    <= zero_div;
                ovf_q     <= 1'b0;
                x_q       <= '0;
            end
            if (step) begin
                qr  <= {qr[QW-2:0], take};
                r   <= rnext;
                cnt <= cnt - CW'(1);
            end
            // DIV1 remainder is checked here before the second divide reuses r.
            if (sub_en) begin
                inexact_q <= (r != '0);
                qr        <= mag_t;
                r         <= '0;
                neg2      <= t[QW-1] ^ ar[WLa-1];
                cnt       <= CW'(WLy);
            end
            if (fin_en) begin
                done_q <= 1'b1;
                if (!div0_q) begin
                    inexact_q <= inexact_q | (r != '0);
                    ovf_q     <= ovf_c;
                    x_q       <= xval;
                end
            end
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.x       = x_q;
    assign bus.inexact = inexact_q;
    assign bus.div0    = div0_q;
    assign bus.ovf     = ovf_q;
endmodule
